calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 174 +++++++++++++++++
 tb/tb_calc_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: turns digit/operator/equals/clear strobes
// into registered load pulses and data for external A, B, opcode and
// result registers.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   digit_valid/digit, op_valid/op, eq_valid, clr - keypad strobes
//   entry_val       - operand data (registered accumulator)
//   op_out          - opcode data
//   load_a/b/op/res - one-cycle load enables
//   a_src_res       - A input mux select (1 = ALU result)
//   state, res_valid, err - status
module calc_sequencer #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            digit_valid,
    input  logic [3:0]      digit,
    input  logic            op_valid,
    input  logic [1:0]      op,
    input  logic            eq_valid,
    input  logic            clr,
    output logic [BITS-1:0] entry_val,
    output logic [1:0]      op_out,
    output logic            load_a,
    output logic            load_b,
    output logic            load_op,
    output logic            load_res,
    output logic            a_src_res,
    output logic [1:0]      state,
    output logic            res_valid,
    output logic            err
);

    typedef enum logic [1:0] {
        ENTRY_A = 2'd0,
        ENTRY_B = 2'd1,
        EXEC    = 2'd2,
        RESULT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] acc_q, acc_d;
    logic [1:0]      op_q, op_d;
    logic            load_a_q, load_a_d;
    logic            load_b_q, load_b_d;
    logic            load_op_q, load_op_d;
    logic            load_res_q, load_res_d;
    logic            a_src_res_q, a_src_res_d;
    logic            res_valid_q, res_valid_d;
    logic            err_q, err_d;

    // Accumulate at BITS+4 bits so acc*10+digit can never wrap.
    logic [BITS+3:0] acc_new;
    logic            acc_ovf;
    logic            digit_ok;

    assign acc_new  = ({4'b0, acc_q} * (BITS+4)'(10))
                    + (BITS+4)'(digit);
    assign acc_ovf  = |acc_new[BITS+3:BITS];
    assign digit_ok = digit_valid && (digit <= 4'd9);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_d        = op_q;
        err_d       = err_q;
        load_a_d    = 1'b0;
        load_b_d    = 1'b0;
        load_op_d   = 1'b0;
        load_res_d  = 1'b0;
        a_src_res_d = 1'b0;

        if (clr) begin
            acc_d     = '0;
            op_d      = 2'd0;
            err_d     = 1'b0;
            load_a_d  = 1'b1;
            load_b_d  = 1'b1;
            load_op_d = 1'b1;
            state_d   = ENTRY_A;
        end else if (state_q == EXEC) begin
            // Single execute cycle; every strobe but clr is dropped.
            state_d = RESULT;
        end else if (eq_valid) begin
            if (state_q == ENTRY_B) begin
                load_res_d = 1'b1;
                state_d    = EXEC;
            end
        end else if (op_valid) begin
            op_d      = op;
            load_op_d = 1'b1;
            unique case (state_q)
                ENTRY_A: begin
                    acc_d    = '0;
                    load_b_d = 1'b1;
                    state_d  = ENTRY_B;
                end
                ENTRY_B: begin
                end
                RESULT: begin
                    // Chain: result becomes A, start a fresh B.
                    acc_d       = '0;
                    load_a_d    = 1'b1;
                    a_src_res_d = 1'b1;
                    load_b_d    = 1'b1;
                    state_d     = ENTRY_B;
                end
                default: begin
                end
            endcase
        end else if (digit_ok) begin
            unique case (state_q)
                ENTRY_A, ENTRY_B: begin
                    if (acc_ovf) begin
                        err_d = 1'b1;
                    end else begin
                        acc_d    = acc_new[BITS-1:0];
                        load_a_d = (state_q == ENTRY_A);
                        load_b_d = (state_q == ENTRY_B);
                    end
                end
                RESULT: begin
                    // New calculation; B keeps its old value.
                    acc_d    = BITS'(digit);
                    load_a_d = 1'b1;
                    state_d  = ENTRY_A;
                end
                default: begin
                end
            endcase
        end

        res_valid_d = (state_d == RESULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ENTRY_A;
            acc_q       <= '0;
            op_q        <= 2'd0;
            err_q       <= 1'b0;
            load_a_q    <= 1'b0;
            load_b_q    <= 1'b0;
            load_op_q   <= 1'b0;
            load_res_q  <= 1'b0;
            a_src_res_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            err_q       <= err_d;
            load_a_q    <= load_a_d;
            load_b_q    <= load_b_d;
            load_op_q   <= load_op_d;
            load_res_q  <= load_res_d;
            a_src_res_q <= a_src_res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign entry_val = acc_q;
    assign op_out    = op_q;
    assign load_a    = load_a_q;
    assign load_b    = load_b_q;
    assign load_op   = load_op_q;
    assign load_res  = load_res_q;
    assign a_src_res = a_src_res_q;
    assign state     = state_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios plus random keypad
// traffic compared each cycle against a behavioural calculator model.
module tb_calc_sequencer;

    localparam int BITS = 8;
    localparam int MAXV = (1 << BITS) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            digit_valid = 1'b0;
    logic [3:0]      digit = '0;
    logic            op_valid = 1'b0;
    logic [1:0]      op = '0;
    logic            eq_valid = 1'b0;
    logic            clr = 1'b0;
    logic [BITS-1:0] entry_val;
    logic [1:0]      op_out;
    logic            load_a, load_b, load_op, load_res;
    logic            a_src_res;
    logic [1:0]      state;
    logic            res_valid;
    logic            err;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the calculator: mode 0..3 = A entry, B entry, exec, result.
    int m_mode, m_acc, m_op, m_err;
    int m_la, m_lb, m_lop, m_lres, m_asr;

    calc_sequencer #(.BITS(BITS)) dut (
        .clk(clk), .reset(reset),
        .digit_valid(digit_valid), .digit(digit),
        .op_valid(op_valid), .op(op),
        .eq_valid(eq_valid), .clr(clr),
        .entry_val(entry_val), .op_out(op_out),
        .load_a(load_a), .load_b(load_b),
        .load_op(load_op), .load_res(load_res),
        .a_src_res(a_src_res), .state(state),
        .res_valid(res_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input int rst, input int c, input int e,
                              input int ov, input int o,
                              input int dv, input int d);
        int nv;
        m_la = 0; m_lb = 0; m_lop = 0; m_lres = 0; m_asr = 0;
        if (rst != 0) begin
            m_mode = 0; m_acc = 0; m_op = 0; m_err = 0;
        end else if (c != 0) begin
            m_mode = 0; m_acc = 0; m_op = 0; m_err = 0;
            m_la = 1; m_lb = 1; m_lop = 1;
        end else if (m_mode == 2) begin
            m_mode = 3;
        end else if (e != 0) begin
            if (m_mode == 1) begin
                m_mode = 2; m_lres = 1;
            end
        end else if (ov != 0) begin
            m_op = o; m_lop = 1;
            if (m_mode == 0) begin
                m_acc = 0; m_lb = 1; m_mode = 1;
            end else if (m_mode == 3) begin
                m_acc = 0; m_la = 1; m_asr = 1; m_lb = 1; m_mode = 1;
            end
        end else if (dv != 0 && d <= 9) begin
            if (m_mode == 3) begin
                m_acc = d; m_la = 1; m_mode = 0;
            end else begin
                nv = m_acc * 10 + d;
                if (nv > MAXV) m_err = 1;
                else begin
                    m_acc = nv;
                    if (m_mode == 0) m_la = 1; else m_lb = 1;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".entry_val"}, int'(entry_val), m_acc);
        chk({tag, ".op_out"}, int'(op_out), m_op);
        chk({tag, ".load_a"}, int'(load_a), m_la);
        chk({tag, ".load_b"}, int'(load_b), m_lb);
        chk({tag, ".load_op"}, int'(load_op), m_lop);
        chk({tag, ".load_res"}, int'(load_res), m_lres);
        chk({tag, ".a_src_res"}, int'(a_src_res), m_asr);
        chk({tag, ".state"}, int'(state), m_mode);
        chk({tag, ".res_valid"}, int'(res_valid), int'(m_mode == 3));
        chk({tag, ".err"}, int'(err), m_err);
    endtask

    // One clock: drive strobes, let the edge happen, check outputs.
    task automatic cyc(input string tag, input int rst, input int c,
                       input int e, input int ov, input int o,
                       input int dv, input int d);
        @(negedge clk);
        reset       = (rst != 0);
        clr         = (c != 0);
        eq_valid    = (e != 0);
        op_valid    = (ov != 0);
        op          = 2'(o);
        digit_valid = (dv != 0);
        digit       = 4'(d);
        @(posedge clk);
        model_step(rst, c, e, ov, o, dv, d);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic dig(input string tag, input int d);
        cyc(tag, 0, 0, 0, 0, 0, 1, d);
    endtask

    initial begin
        m_mode = 0; m_acc = 0; m_op = 0; m_err = 0;
        cyc("rst0", 1, 0, 0, 0, 0, 0, 0);
        cyc("rst1", 1, 0, 0, 0, 0, 0, 0);

        // 12 op1 3 =
        dig("d1", 1);
        chk("d1.lit", int'(entry_val), 1);
        dig("d2", 2);
        chk("d2.lit", int'(entry_val), 12);
        cyc("op1", 0, 0, 0, 1, 1, 0, 0);
        chk("op1.lit_lb", int'(load_b), 1);
        dig("d3", 3);
        chk("d3.lit_b", int'(entry_val), 3);
        cyc("eq", 0, 0, 1, 0, 0, 0, 0);
        chk("exec.lit", int'(load_res), 1);
        idle("exec_done");
        chk("res.lit", int'(res_valid), 1);
        idle("res_hold");

        // chaining from RESULT
        cyc("chain", 0, 0, 0, 1, 2, 0, 0);
        chk("chain.lit_asr", int'(a_src_res), 1);
        chk("chain.lit_state", int'(state), 1);

        // clr beats digit in ENTRY_B
        cyc("clr_dig", 0, 1, 0, 0, 0, 1, 7);
        chk("clr_dig.lit", int'(entry_val), 0);

        // overflow at 255
        dig("o2", 2); dig("o5", 5); dig("o5b", 5);
        chk("ovf.lit255", int'(entry_val), 255);
        dig("o6", 6);
        chk("ovf.lit_err", int'(err), 1);
        chk("ovf.lit_la", int'(load_a), 0);
        cyc("clr", 0, 1, 0, 0, 0, 0, 0);
        chk("clr.lit_err", int'(err), 0);

        // eq with illegal digit in ENTRY_A; lone illegal digit
        cyc("eq_a", 0, 0, 1, 0, 0, 1, 12);
        dig("d12", 12);
        dig("d15", 15);

        // reset during EXEC
        dig("r4", 4);
        cyc("rop", 0, 0, 0, 1, 3, 0, 0);
        dig("r9", 9);
        cyc("req", 0, 0, 1, 0, 0, 0, 0);
        cyc("rst_exec", 1, 0, 0, 0, 0, 0, 0);
        chk("rst_exec.lit", int'(load_res), 0);

        // random traffic, biased toward digits
        for (int i = 0; i < 600; i++) begin
            int r, rs, c, e, ov, dv;
            r  = $urandom_range(0, 99);
            rs = (r < 2) ? 1 : 0;
            c  = ($urandom_range(0, 29) == 0) ? 1 : 0;
            e  = ($urandom_range(0, 6) == 0) ? 1 : 0;
            ov = ($urandom_range(0, 5) == 0) ? 1 : 0;
            dv = ($urandom_range(0, 2) != 0) ? 1 : 0;
            cyc("rnd", rs, c, e, ov, $urandom_range(0, 3),
                dv, $urandom_range(0, 15));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
